// File: rtl/audio_pkg.sv
// Shared types and constants for the PCM playback path: FSM states,
// the phase-increment ceiling and the frame size for each sample format.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        OUTPUT
    } state_e;

    localparam logic [7:0] RATE_MAX = 8'd128;

    localparam logic [2:0] BYTES_8_MONO    = 3'd1;
    localparam logic [2:0] BYTES_8_STEREO  = 3'd2;
    localparam logic [2:0] BYTES_16_MONO   = 3'd2;
    localparam logic [2:0] BYTES_16_STEREO = 3'd4;

    function automatic logic [2:0] frame_bytes(input logic is16, input logic stereo);
        logic [2:0] n;
        case ({is16, stereo})
            2'b00:   n = BYTES_8_MONO;
            2'b01:   n = BYTES_8_STEREO;
            2'b10:   n = BYTES_16_MONO;
            default: n = BYTES_16_STEREO;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pcm_rate_accum.sv
// Phase accumulator: each tick adds the (clamped) rate to the low seven bits
// of the accumulator; a set bit 7 in the sum means a new frame is due.
module pcm_rate_accum
    import audio_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [7:0] rate,
    input  logic       clear,
    output logic       frame_req
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;
    logic [7:0] rate_eff;

    always_comb begin
        rate_eff  = (rate > RATE_MAX) ? RATE_MAX : rate;
        acc_d     = (acc_q & 8'h7F) + rate_eff;
        frame_req = tick && !clear && acc_d[7];
    end

    // clear wins over a simultaneous tick so a flush never leaves a stray phase
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
        end else if (tick) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pcm_playback_ctrl.sv
// PCM playback controller: turns rate-accumulator frame requests into FIFO
// byte fetches, assembles L/R samples, attenuates them and presents them.
module pcm_playback_ctrl
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_tick,
    input  logic [7:0]  cfg_rate,
    input  logic        cfg_16bit,
    input  logic        cfg_stereo,
    input  logic [3:0]  cfg_atten,
    input  logic        flush,
    output logic        fifo_rd_en,
    input  logic [7:0]  fifo_rddata,
    input  logic        fifo_empty,
    input  logic        fifo_almost_empty,
    output logic [15:0] left_out,
    output logic [15:0] right_out,
    output logic        sample_valid,
    output logic        underrun,
    input  logic        irq_en,
    output logic        irq
);

    state_e      state_q;
    logic        pending_q;
    logic        underrun_q;
    logic        rd_taken_q;
    logic        is16_q;
    logic        stereo_q;
    logic [3:0]  atten_q;
    logic [2:0]  nbytes_q;
    logic [1:0]  byte_idx_q;
    logic [7:0]  samp_q [4];
    logic [15:0] left_q;
    logic [15:0] right_q;
    logic        sample_valid_q;
    logic        irq_q;

    logic        frame_req;
    logic [7:0]  cap_byte;
    logic [1:0]  slot;
    logic [7:0]  samp_d [4];
    logic [15:0] left_full;
    logic [15:0] right_full;
    logic [15:0] left_d;
    logic [15:0] right_d;
    logic        last_byte;

    pcm_rate_accum u_accum (
        .clk       (clk),
        .rst       (rst),
        .tick      (sample_tick),
        .rate      (cfg_rate),
        .clear     (flush),
        .frame_req (frame_req)
    );

    // Sample buffer slots are L_lo, L_hi, R_lo, R_hi; 8-bit bytes land in the high slots
    always_comb begin
        cap_byte   = rd_taken_q ? fifo_rddata : 8'h00;
        slot       = is16_q ? byte_idx_q : {byte_idx_q[0], 1'b1};
        samp_d     = samp_q;
        samp_d[slot] = cap_byte;
        left_full  = {samp_d[1], samp_d[0]};
        right_full = stereo_q ? {samp_d[3], samp_d[2]} : left_full;
        left_d     = $signed(left_full) >>> atten_q;
        right_d    = $signed(right_full) >>> atten_q;
        last_byte  = ({1'b0, byte_idx_q} == (nbytes_q - 3'd1));
        fifo_rd_en = (state_q == FETCH) && !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pending_q      <= 1'b0;
            underrun_q     <= 1'b0;
            rd_taken_q     <= 1'b0;
            is16_q         <= 1'b0;
            stereo_q       <= 1'b0;
            atten_q        <= '0;
            nbytes_q       <= BYTES_8_MONO;
            byte_idx_q     <= '0;
            samp_q         <= '{default: 8'h00};
            left_q         <= '0;
            right_q        <= '0;
            sample_valid_q <= 1'b0;
            irq_q          <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            irq_q          <= irq_en && fifo_almost_empty;
            if (flush) begin
                state_q    <= IDLE;
                pending_q  <= 1'b0;
                underrun_q <= 1'b0;
            end else begin
                // A request landing while one is already pending is simply absorbed
                if (state_q == IDLE && pending_q) begin
                    pending_q <= 1'b0;
                end else if (frame_req) begin
                    pending_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (pending_q) begin
                            state_q    <= FETCH;
                            is16_q     <= cfg_16bit;
                            stereo_q   <= cfg_stereo;
                            atten_q    <= cfg_atten;
                            nbytes_q   <= frame_bytes(cfg_16bit, cfg_stereo);
                            byte_idx_q <= '0;
                            samp_q     <= '{default: 8'h00};
                        end
                    end
                    FETCH: begin
                        rd_taken_q <= !fifo_empty;
                        if (fifo_empty) begin
                            underrun_q <= 1'b1;
                        end
                        state_q <= CAPTURE;
                    end
                    CAPTURE: begin
                        samp_q <= samp_d;
                        if (last_byte) begin
                            left_q         <= left_d;
                            right_q        <= right_d;
                            sample_valid_q <= 1'b1;
                            state_q        <= OUTPUT;
                        end else begin
                            byte_idx_q <= byte_idx_q + 2'd1;
                            state_q    <= FETCH;
                        end
                    end
                    OUTPUT: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign left_out     = left_q;
    assign right_out    = right_q;
    assign sample_valid = sample_valid_q;
    assign underrun     = underrun_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_pcm_playback_ctrl.sv
// Scoreboard bench for pcm_playback_ctrl: a byte FIFO model feeds the DUT and
// expected L/R pairs are queued per frame, then popped on each sample_valid.
module tb_pcm_playback_ctrl;
    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sampleTick = 1'b0;
    logic [7:0]  cfgRate = 8'd0;
    logic        cfg16 = 1'b0;
    logic        cfgStereo = 1'b0;
    logic [3:0]  cfgAtten = 4'd0;
    logic        flush = 1'b0;
    logic        fifoRdEn;
    logic [7:0]  fifoRdData = 8'h00;
    logic        fifoEmpty;
    logic        almostEmpty = 1'b0;
    logic [15:0] leftOut;
    logic [15:0] rightOut;
    logic        sampleValid;
    logic        underrun;
    logic        irqEn = 1'b0;
    logic        irq;

    int          testCount = 0;
    int          failCount = 0;
    int          rdCount = 0;
    int          validCount = 0;
    logic [31:0] expQ[$];
    logic [31:0] monExp;
    logic [7:0]  fifoMem [64];
    int          wrPtr = 0;
    int          rdPtr = 0;
    int          base;
    int          vBase;
    int          waitCnt;

    pcm_playback_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .sample_tick       (sampleTick),
        .cfg_rate          (cfgRate),
        .cfg_16bit         (cfg16),
        .cfg_stereo        (cfgStereo),
        .cfg_atten         (cfgAtten),
        .flush             (flush),
        .fifo_rd_en        (fifoRdEn),
        .fifo_rddata       (fifoRdData),
        .fifo_empty        (fifoEmpty),
        .fifo_almost_empty (almostEmpty),
        .left_out          (leftOut),
        .right_out         (rightOut),
        .sample_valid      (sampleValid),
        .underrun          (underrun),
        .irq_en            (irqEn),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    assign fifoEmpty = (wrPtr == rdPtr);

    // FIFO model: data appears the cycle after an accepted read
    always @(posedge clk) begin
        if (fifoRdEn && !fifoEmpty) begin
            fifoRdData <= fifoMem[rdPtr[5:0]];
            rdPtr      <= rdPtr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Monitor: counts read strobes and scores every sample_valid pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (fifoRdEn) rdCount++;
            if (sampleValid) begin
                validCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(validCount), 32'(0));
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("leftOut", {16'h0, leftOut}, {16'h0, monExp[31:16]});
                    checkOutput("rightOut", {16'h0, rightOut}, {16'h0, monExp[15:0]});
                end
            end
        end
    end

    task automatic pushByte(input logic [7:0] b);
        fifoMem[wrPtr[5:0]] = b;
        wrPtr++;
    endtask

    task automatic pushExp(input logic [15:0] l, input logic [15:0] r);
        expQ.push_back({l, r});
    endtask

    task automatic setCfg(input logic [7:0] rate, input logic is16, input logic stereo, input logic [3:0] atten);
        cfgRate   = rate;
        cfg16     = is16;
        cfgStereo = stereo;
        cfgAtten  = atten;
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            sampleTick = 1'b1;
            @(negedge clk);
            sampleTick = 1'b0;
            repeat (19) @(negedge clk);
        end
    endtask

    task automatic doFlush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic waitDrain();
        int i = 0;
        while (expQ.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (expQ.size() != 0) begin
            checkOutput("drainTimeout", 32'(expQ.size()), 32'(0));
            expQ.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic waitRdEn(input string tag);
        int i = 0;
        while (!fifoRdEn && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (!fifoRdEn) checkOutput(tag, 32'(0), 32'(1));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        irqEn       = 1'b1;
        almostEmpty = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("resetLeft", {16'h0, leftOut}, 32'h0);
        checkOutput("resetRight", {16'h0, rightOut}, 32'h0);
        checkOutput("resetValid", {31'h0, sampleValid}, 32'h0);
        checkOutput("resetUnderrun", {31'h0, underrun}, 32'h0);
        checkOutput("resetIrq", {31'h0, irq}, 32'h0);
        checkOutput("resetRdEn", {31'h0, fifoRdEn}, 32'h0);
        checkOutput("resetState", 32'(dut.state_q), 32'(IDLE));
        irqEn       = 1'b0;
        almostEmpty = 1'b0;
        rst         = 1'b0;
        @(negedge clk);

        // 8-bit mono at full rate
        setCfg(8'd128, 1'b0, 1'b0, 4'd0);
        pushByte(8'h40); pushByte(8'h80);
        pushExp(16'h4000, 16'h4000); pushExp(16'h8000, 16'h8000);
        base = rdCount;
        applyStimulus(2);
        waitDrain();
        checkOutput("monoRdCount", 32'(rdCount - base), 32'd2);
        checkOutput("monoUnderrun", {31'h0, underrun}, 32'h0);

        // Half rate: eight ticks give four frames
        doFlush();
        setCfg(8'd64, 1'b0, 1'b0, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            pushByte(8'(i));
            pushExp({8'(i), 8'h00}, {8'(i), 8'h00});
        end
        base  = rdCount;
        vBase = validCount;
        applyStimulus(8);
        waitDrain();
        checkOutput("halfRateRdCount", 32'(rdCount - base), 32'd4);
        checkOutput("halfRateFrames", 32'(validCount - vBase), 32'd4);

        // 16-bit stereo, little-endian L then R
        setCfg(8'd128, 1'b1, 1'b1, 4'd0);
        pushByte(8'h34); pushByte(8'h12); pushByte(8'h78); pushByte(8'h56);
        pushExp(16'h1234, 16'h5678);
        base = rdCount;
        applyStimulus(1);
        waitDrain();
        checkOutput("stereo16RdCount", 32'(rdCount - base), 32'd4);

        // Attenuation keeps the sign
        setCfg(8'd128, 1'b0, 1'b0, 4'd4);
        pushByte(8'h80);
        pushExp(16'hF800, 16'hF800);
        base = rdCount;
        applyStimulus(1);
        setCfg(8'd128, 1'b0, 1'b1, 4'd1);
        pushByte(8'h7F); pushByte(8'h80);
        pushExp(16'h3F80, 16'hC000);
        applyStimulus(1);
        waitDrain();
        checkOutput("attenRdCount", 32'(rdCount - base), 32'd3);

        // Underrun on a short 16-bit stereo frame
        doFlush();
        setCfg(8'd128, 1'b1, 1'b1, 4'd0);
        pushByte(8'hCD); pushByte(8'hAB);
        pushExp(16'hABCD, 16'h0000);
        base = rdCount;
        applyStimulus(1);
        waitDrain();
        checkOutput("underrunRdCount", 32'(rdCount - base), 32'd2);
        checkOutput("underrunSet", {31'h0, underrun}, 32'h1);
        doFlush();
        checkOutput("underrunCleared", {31'h0, underrun}, 32'h0);
        checkOutput("flushHoldLeft", {16'h0, leftOut}, 32'h0000ABCD);

        // Flush in the cycle after the first CAPTURE abandons the frame
        pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
        sampleTick = 1'b1;
        @(negedge clk);
        sampleTick = 1'b0;
        waitRdEn("abortFirstFetch");
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abortState", 32'(dut.state_q), 32'(IDLE));
        checkOutput("abortUnderrun", {31'h0, underrun}, 32'h0);
        checkOutput("abortHoldLeft", {16'h0, leftOut}, 32'h0000ABCD);
        checkOutput("abortHoldRight", {16'h0, rightOut}, 32'h0);
        wrPtr = rdPtr;

        // Rate zero never requests a frame
        setCfg(8'd0, 1'b0, 1'b0, 4'd0);
        pushByte(8'h55);
        base = rdCount;
        applyStimulus(3);
        checkOutput("rateZeroRdCount", 32'(rdCount - base), 32'd0);
        checkOutput("rateZeroHoldLeft", {16'h0, leftOut}, 32'h0000ABCD);

        // Flush beats a simultaneous tick
        setCfg(8'd128, 1'b0, 1'b0, 4'd0);
        base = rdCount;
        sampleTick = 1'b1;
        flush      = 1'b1;
        @(negedge clk);
        sampleTick = 1'b0;
        flush      = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("flushPriorityRdCount", 32'(rdCount - base), 32'd0);
        wrPtr = rdPtr;

        // Rates above 128 behave as 128
        doFlush();
        setCfg(8'd200, 1'b0, 1'b0, 4'd0);
        pushByte(8'h10); pushByte(8'h20);
        pushExp(16'h1000, 16'h1000); pushExp(16'h2000, 16'h2000);
        base = rdCount;
        applyStimulus(2);
        waitDrain();
        checkOutput("clampRdCount", 32'(rdCount - base), 32'd2);

        // Registered interrupt
        irqEn       = 1'b1;
        almostEmpty = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("irqHigh", {31'h0, irq}, 32'h1);
        almostEmpty = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("irqLow", {31'h0, irq}, 32'h0);
        irqEn = 1'b0;

        // Reset mid-frame abandons the frame
        setCfg(8'd128, 1'b1, 1'b1, 4'd0);
        pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC); pushByte(8'hDD);
        sampleTick = 1'b1;
        @(negedge clk);
        sampleTick = 1'b0;
        waitRdEn("rstFirstFetch");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        base = rdCount;
        repeat (20) @(negedge clk);
        checkOutput("rstRdCount", 32'(rdCount - base), 32'd0);
        checkOutput("rstLeft", {16'h0, leftOut}, 32'h0);
        checkOutput("rstRight", {16'h0, rightOut}, 32'h0);
        checkOutput("rstState", 32'(dut.state_q), 32'(IDLE));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
